// File: rtl/avalon_led_pio_pkg.sv
// Shared definitions for the Avalon LED PIO with blink.
// Holds the slave register map and the STATUS bit layout.
package avalon_led_pio_pkg;

    // Word addresses of the slave register map.
    typedef enum logic [2:0] {
        ADDR_DATA     = 3'd0,
        ADDR_BLINK_EN = 3'd1,
        ADDR_PERIOD   = 3'd2,
        ADDR_OUTSET   = 3'd3,
        ADDR_OUTCLEAR = 3'd4,
        ADDR_STATUS   = 3'd5,
        ADDR_RSVD6    = 3'd6,
        ADDR_RSVD7    = 3'd7
    } pio_addr_e;

    // Position of the blink phase flag in STATUS.
    localparam int unsigned STATUS_PHASE_BIT = 0;

endpackage

// File: rtl/avalon_led_pio_blink_timer.sv
// Blink half-period timer.
// Counts 0..period and toggles phase on every wrap. A restart pulse
// reloads the count and forces phase high, whatever the period value.
// Ports:
//   clk     - system clock
//   reset   - synchronous active-high reset
//   period  - half-period minus one, in clk cycles
//   restart - one-cycle pulse: cnt <= 0, phase <= 1
//   phase   - current blink phase (1 = blinking bits on)
module led_blink_timer #(
    parameter int unsigned PRESCALE_W = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [PRESCALE_W-1:0] period,
    input  logic                  restart,
    output logic                  phase
);

    logic [PRESCALE_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            cnt   <= '0;
            phase <= 1'b1;
        end else if (cnt == period) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt   <= cnt + PRESCALE_W'(1);
        end
    end

endmodule

// File: rtl/avalon_led_pio_blink.sv
// Avalon-MM output PIO for LEDs and discrete outputs, with atomic
// set/clear registers and per-bit hardware blink.
// Ports:
//   clk        - system clock
//   reset      - synchronous active-high reset
//   address    - word address (see avalon_led_pio_pkg)
//   chipselect - slave select
//   write_n    - active-low write strobe
//   writedata  - write data
//   readdata   - read data, combinational from address, zero wait states
//   out_port   - registered output pins
module avalon_led_pio_blink
    import avalon_led_pio_pkg::*;
#(
    parameter int unsigned      WIDTH          = 4,
    parameter int unsigned      PRESCALE_W     = 24,
    parameter logic [WIDTH-1:0] RESET_VALUE    = '0,
    parameter int unsigned      DEFAULT_PERIOD = 12499999
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [PRESCALE_W-1:0] PERIOD_INIT = PRESCALE_W'(DEFAULT_PERIOD);

    logic [WIDTH-1:0]      data_q;
    logic [WIDTH-1:0]      blink_en_q;
    logic [PRESCALE_W-1:0] period_q;
    logic                  phase;
    logic                  wr_en;
    logic                  period_wr;
    logic [WIDTH-1:0]      wd_bits;
    logic [WIDTH-1:0]      next_out;
    pio_addr_e             addr_e;
    logic                  unused_wd;

    assign addr_e    = pio_addr_e'(address);
    assign wr_en     = chipselect && !write_n;
    assign period_wr = wr_en && (addr_e == ADDR_PERIOD);
    assign wd_bits   = writedata[WIDTH-1:0];
    // Upper writedata bits are intentionally ignored for narrow configs.
    assign unused_wd = ^writedata;

    led_blink_timer #(
        .PRESCALE_W (PRESCALE_W)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .period  (period_q),
        .restart (period_wr),
        .phase   (phase)
    );

    // Blinking bits are masked off during the low phase.
    assign next_out = data_q & ~(blink_en_q & {WIDTH{~phase}});

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q     <= RESET_VALUE;
            blink_en_q <= '0;
            period_q   <= PERIOD_INIT;
            out_port   <= RESET_VALUE;
        end else begin
            out_port <= next_out;
            if (wr_en) begin
                case (addr_e)
                    ADDR_DATA:     data_q     <= wd_bits;
                    ADDR_BLINK_EN: blink_en_q <= wd_bits;
                    ADDR_PERIOD:   period_q   <= writedata[PRESCALE_W-1:0];
                    ADDR_OUTSET:   data_q     <= data_q | wd_bits;
                    ADDR_OUTCLEAR: data_q     <= data_q & ~wd_bits;
                    default:       ;
                endcase
            end
        end
    end

    always_comb begin
        readdata = '0;
        case (addr_e)
            ADDR_DATA:     readdata[WIDTH-1:0]      = data_q;
            ADDR_BLINK_EN: readdata[WIDTH-1:0]      = blink_en_q;
            ADDR_PERIOD:   readdata[PRESCALE_W-1:0] = period_q;
            ADDR_STATUS:   readdata[STATUS_PHASE_BIT] = phase;
            default:       ;
        endcase
    end

endmodule
